serial_alu_ctrl: RTL

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu1bit.sv | 33 +++
 rtl/serial_alu_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types for the bit-serial ALU slice.
//   op_e    : 2-bit operation code (NOR, XOR, ADD, SUB = a-b)
//   state_e : controller FSM states
//   op_is_arith : true for ops that use the carry chain
package alu_pkg;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  function automatic logic op_is_arith(op_e o);
    return (o == OP_ADD) || (o == OP_SUB);
  endfunction

endpackage

// File: rtl/alu1bit.sv
// One-bit ALU slice, purely combinational.
//   a, b : operand bits        cin : carry in
//   op   : operation code      s   : result bit   cout : carry out
// SUB is a + ~b + cin; the caller seeds cin=1 on the LSB slice.
// cout is only meaningful for ADD/SUB and is 0 otherwise.
module alu1bit
  import alu_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  op_e  op,
  output logic s,
  output logic cout
);

  logic bx;

  always_comb begin
    bx   = (op == OP_SUB) ? ~b : b;
    s    = 1'b0;
    cout = 1'b0;
    case (op)
      OP_NOR: s = ~(a | b);
      OP_XOR: s = a ^ b;
      default: begin
        s    = a ^ bx ^ cin;
        cout = (a & bx) | (cin & (a ^ bx));
      end
    endcase
  end

endmodule

// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU controller: feeds one operand bit pair per cycle (LSB
// first) through a single alu1bit, registering the carry between slices.
//   clk, rst     : clock, async active-high reset
//   start        : begin an operation (accepted in IDLE/DONE only)
//   a, b, op     : operands / op code, captured on the accepting edge
//   busy         : high for the WIDTH processing cycles
//   done         : one-cycle pulse, result valid
//   result, cout, zero : last completed result, final carry, result==0
//   ovf          : signed overflow (only with SERIAL_ALU_OVF_EN defined)
// Optional feature macro: SERIAL_ALU_OVF_EN
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr, r_next;
  op_e              op_q;
  logic [CW-1:0]    cnt;
  logic             c_q, s1, c1;
  logic             accept, last;

  alu1bit u_alu (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c_q),
    .op   (op_q),
    .s    (s1),
    .cout (c1)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB sum.
  assign r_next = {s1, r_sr[WIDTH-1:1]};

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    last     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = S_RUN;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last     = 1'b1;
          state_nx = S_DONE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      op_q   <= OP_NOR;
      cnt    <= '0;
      c_q    <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
      zero   <= 1'b1;
`ifdef SERIAL_ALU_OVF_EN
      ovf    <= 1'b0;
`endif
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      op_q <= op_e'(op);
      cnt  <= '0;
      // SUB = a + ~b + 1: the +1 rides in as the LSB carry.
      c_q  <= (op_e'(op) == OP_SUB);
    end else if (state == S_RUN) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      r_sr <= r_next;
      c_q  <= c1;
      cnt  <= cnt + CW'(1);
      if (last) begin
        result <= r_next;
        cout   <= op_is_arith(op_q) & c1;
        zero   <= (r_next == '0);
`ifdef SERIAL_ALU_OVF_EN
        // c_q is the carry into the MSB slice on this final edge.
        ovf    <= op_is_arith(op_q) & (c_q ^ c1);
`endif
      end
    end
  end

endmodule
